wb_regfile_arbiter: RTL

- Arbitrates the single register-file write port between the pipeline write-back stage and an auxiliary multi-cycle requester (mult/div unit, or the debug loader).
- Write-back has priority. The aux side uses a valid/ready handshake.
- A starvation counter forces an aux slot and asks the hazard unit to stall the pipeline.
- Sits between write-back output, aux unit and register file; all register-file write signals are registered.

---
 rtl/wb_regfile_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wb_regfile_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : wb_regfile_arbiter                                               |
// | Purpose : Shares the register-file write port between write-back and an    |
// |           auxiliary valid/ready requester, with starvation-forced slots.   |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module wb_regfile_arbiter #(
  parameter int B       = 32,
  parameter int D       = 5,
  parameter int MAXWAIT = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         wb_valid_i,
  input  logic [D-1:0] wb_addr_i,
  input  logic [B-1:0] wb_data_i,
  input  logic         aux_valid_i,
  input  logic [D-1:0] aux_addr_i,
  input  logic [B-1:0] aux_data_i,
  output logic         aux_ready_o,
  output logic         rf_we_o,
  output logic [D-1:0] rf_addr_o,
  output logic [B-1:0] rf_data_o,
  output logic         stall_req_o,
  output logic [3:0]   aux_wait_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FORCE = 1'b1
  } state_e;

  localparam logic [3:0] c_maxwait = 4'(MAXWAIT);

  state_e       state_q, state_d;
  logic [3:0]   wait_q, wait_d;
  logic         hold_full_q, hold_full_d;
  logic [D-1:0] hold_addr_q, hold_addr_d;
  logic [B-1:0] hold_data_q, hold_data_d;
  logic         rf_we_q, rf_we_d;
  logic [D-1:0] rf_addr_q, rf_addr_d;
  logic [B-1:0] rf_data_q, rf_data_d;

  logic         w_ready;
  logic         w_win;
  logic [D-1:0] w_win_addr;
  logic [B-1:0] w_win_data;
  logic [3:0]   w_wait_inc;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    hold_full_d = hold_full_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    w_ready     = 1'b0;
    w_win       = 1'b0;
    w_win_addr  = '0;
    w_win_data  = '0;
    w_wait_inc  = (wait_q == c_maxwait) ? wait_q : wait_q + 4'd1;

    case (state_q)
      ST_IDLE: begin
        w_ready     = ~hold_full_q & ~wb_valid_i;
        hold_full_d = hold_full_q & wb_valid_i;
        if (hold_full_q) begin
          w_win      = 1'b1;
          w_win_addr = hold_addr_q;
          w_win_data = hold_data_q;
          // A write-back arriving while the hold drains is re-captured, never dropped.
          if (wb_valid_i) begin
            hold_addr_d = wb_addr_i;
            hold_data_d = wb_data_i;
          end
        end else if (wb_valid_i) begin
          w_win      = 1'b1;
          w_win_addr = wb_addr_i;
          w_win_data = wb_data_i;
        end else if (aux_valid_i) begin
          w_win      = 1'b1;
          w_win_addr = aux_addr_i;
          w_win_data = aux_data_i;
        end

        if (aux_valid_i & ~w_ready) begin
          wait_d = w_wait_inc;
          if (w_wait_inc == c_maxwait) begin
            state_d = ST_FORCE;
          end
        end else begin
          wait_d = '0;
        end
      end

      ST_FORCE: begin
        // An occupied hold entry is older than the aux write, so it goes first.
        w_ready     = aux_valid_i & ~hold_full_q;
        hold_full_d = wb_valid_i;
        if (wb_valid_i) begin
          hold_addr_d = wb_addr_i;
          hold_data_d = wb_data_i;
        end
        if (hold_full_q) begin
          w_win      = 1'b1;
          w_win_addr = hold_addr_q;
          w_win_data = hold_data_q;
        end else if (w_ready) begin
          w_win      = 1'b1;
          w_win_addr = aux_addr_i;
          w_win_data = aux_data_i;
        end
        if (w_ready | ~aux_valid_i) begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Writes to register 0 are consumed but never reach the register file.
    rf_we_d   = w_win & (w_win_addr != '0);
    rf_addr_d = rf_we_d ? w_win_addr : rf_addr_q;
    rf_data_d = rf_we_d ? w_win_data : rf_data_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      hold_full_q <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      hold_full_q <= hold_full_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
    end
  end

  assign aux_ready_o = w_ready & ~reset_i;
  assign rf_we_o     = rf_we_q;
  assign rf_addr_o   = rf_addr_q;
  assign rf_data_o   = rf_data_q;
  assign stall_req_o = (state_q == ST_FORCE) | hold_full_q;
  assign aux_wait_o  = wait_q;

endmodule
`default_nettype wire
